// File: rtl/pe_au_param.sv
// PE arithmetic unit for the FIOS Montgomery datapath: pipelined WIDTH x WIDTH
// multiply with a selectable accumulate (zero, C, P, or P >> WIDTH).
module pe_au_param #(
  parameter  int WIDTH = 17,
  parameter  int GUARD = 2,
  parameter  int ABREG = 1,
  parameter  int MREG  = 1,
  parameter  int CREG  = 1,
  localparam int PW    = 2*WIDTH + GUARD,
  localparam int LAT   = ABREG + MREG + 1
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             valid_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_en_i,
  input  logic [PW-1:0]    c_i,
  output logic             valid_o,
  output logic [PW-1:0]    p_o,
  output logic             carry_o
);

  localparam int PM = 2*WIDTH;
  localparam int D  = LAT - 1;              // control delay up to the P stage
  localparam int DS = (D == 0) ? 1 : D;
  localparam int AS = (ABREG == 0) ? 1 : ABREG;

  localparam logic [1:0] M_ZERO = 2'b00, M_ADDC = 2'b01, M_ADDP = 2'b10, M_ADDPSH = 2'b11;

  if (WIDTH < 2 || WIDTH > 26 || ABREG > 2 || ABREG < 0 || MREG > 1 || MREG < 0 ||
      CREG > 1 || CREG < 0) begin : g_bad_param
    $error("pe_au_param: illegal parameter combination");
  end

  logic [AS-1:0][WIDTH-1:0] a_q, b_q;
  logic [DS-1:0]            vld_pipe_q;
  logic [DS-1:0][1:0]       mode_q;
  logic [PM-1:0]            m_q;
  logic [PW-1:0]            c_q, p_q;
  logic                     carry_q, valid_q;

  logic [WIDTH-1:0] a_s, b_s;
  logic [PM-1:0]    prod, m_f;
  logic             vld_f;
  logic [1:0]       mode_f;
  logic [PW-1:0]    c_f, addend, p_d;
  logic [PW:0]      sum;
  logic             carry_d;

  // Stage taps: a zero-depth stage falls through to the raw input.
  assign a_s    = (ABREG == 0) ? a_i : a_q[AS-1];
  assign b_s    = (ABREG == 0) ? b_i : b_q[AS-1];
  assign prod   = PM'(a_s) * PM'(b_s);
  assign m_f    = (MREG == 0) ? prod : m_q;
  assign vld_f  = (D == 0) ? valid_i : vld_pipe_q[DS-1];
  assign mode_f = (D == 0) ? mode_i : mode_q[DS-1];
  assign c_f    = (CREG == 0) ? c_i : c_q;

  // P feedback is the live register, so back-to-back ops chain without stalls.
  always_comb begin
    addend = '0;
    unique case (mode_f)
      M_ZERO:   addend = '0;
      M_ADDC:   addend = c_f;
      M_ADDP:   addend = p_q;
      M_ADDPSH: addend = p_q >> WIDTH;
      default:  addend = '0;
    endcase
    sum = {1'b0, PW'(m_f)} + {1'b0, addend};
  end

  assign p_d     = sum[PW-1:0];
  assign carry_d = sum[PW];

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      a_q        <= '0;
      b_q        <= '0;
      vld_pipe_q <= '0;
      mode_q     <= '0;
      m_q        <= '0;
      c_q        <= '0;
      p_q        <= '0;
      carry_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      a_q[0] <= a_i;
      b_q[0] <= b_i;
      for (int s = 1; s < AS; s++) begin
        a_q[s] <= a_q[s-1];
        b_q[s] <= b_q[s-1];
      end
      vld_pipe_q[0] <= valid_i;
      mode_q[0]     <= mode_i;
      for (int s = 1; s < DS; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        mode_q[s]     <= mode_q[s-1];
      end
      m_q <= prod;
      if (CREG != 0 && c_en_i) c_q <= c_i;
      valid_q <= vld_f;
      if (vld_f) begin
        p_q     <= p_d;
        carry_q <= carry_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign p_o     = p_q;
  assign carry_o = carry_q;

endmodule

// File: tb/tb_pe_au_param.sv
// Bench for pe_au_param: directed steps plus random traffic against a
// cycle-history reference model, run on two parameterisations at once.
module tb_pe_au_param;
  localparam int W  = 17;
  localparam int PW = 2*W + 2;
  localparam int HN = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, valid, cen;
  logic [1:0]    mode;
  logic [W-1:0]  a, b;
  logic [PW-1:0] c;
  logic          vo0, co0, vo1, co1;
  logic [PW-1:0] p0, p1;

  pe_au_param dut0 (
    .clock_i(clk), .reset_n_i(rst_n), .valid_i(valid), .mode_i(mode),
    .a_i(a), .b_i(b), .c_en_i(cen), .c_i(c),
    .valid_o(vo0), .p_o(p0), .carry_o(co0));

  pe_au_param #(.ABREG(2), .MREG(1), .CREG(0)) dut1 (
    .clock_i(clk), .reset_n_i(rst_n), .valid_i(valid), .mode_i(mode),
    .a_i(a), .b_i(b), .c_en_i(cen), .c_i(c),
    .valid_o(vo1), .p_o(p1), .carry_o(co1));

  int checks = 0, errors = 0, n = 0;

  // Model: history of issued ops by edge number; each edge retires the op
  // issued LAT-1 edges earlier unless a reset edge came after its issue.
  logic          hv [HN];
  logic [1:0]    hm [HN];
  logic [63:0]   hprod [HN];
  int            lat [2] = '{3, 4};
  bit            creg [2] = '{1'b1, 1'b0};
  int            rst_edge [2] = '{-100, -100};
  logic [PW-1:0] mp [2];
  logic          mc [2], mv [2];
  logic [PW-1:0] mcq [2];

  task automatic model_edge();
    logic [63:0] add, sum, cval;
    int e;
    hv[n]    = valid;
    hm[n]    = mode;
    hprod[n] = 64'(a) * 64'(b);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mp[i] = '0; mc[i] = 1'b0; mv[i] = 1'b0; mcq[i] = '0; rst_edge[i] = n;
      end else begin
        e = n - lat[i] + 1;
        if (e > rst_edge[i] && e >= 0 && hv[e]) begin
          cval = creg[i] ? 64'(mcq[i]) : 64'(c);
          case (hm[e])
            2'd0:    add = 0;
            2'd1:    add = cval;
            2'd2:    add = 64'(mp[i]);
            default: add = 64'(mp[i]) / (64'd1 << W);
          endcase
          sum   = hprod[e] + add;
          mp[i] = sum[PW-1:0];
          mc[i] = sum[PW];
          mv[i] = 1'b1;
        end else begin
          mv[i] = 1'b0;
        end
        if (creg[i] && cen) mcq[i] = c;
      end
    end
    n++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] md,
                      input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic ce, input logic [PW-1:0] cc);
    rst_n = r; valid = v; mode = md; a = aa; b = bb; cen = ce; c = cc;
    @(posedge clk);
    model_edge();
    #1;
    check("dut0.valid_o", 64'(vo0), 64'(mv[0]));
    check("dut0.p_o",     64'(p0),  64'(mp[0]));
    check("dut0.carry_o", 64'(co0), 64'(mc[0]));
    check("dut1.valid_o", 64'(vo1), 64'(mv[1]));
    check("dut1.p_o",     64'(p1),  64'(mp[1]));
    check("dut1.carry_o", 64'(co1), 64'(mc[1]));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1, 0, 2'd0, '0, '0, 0, '0);
  endtask

  initial begin
    rst_n = 0; valid = 0; mode = 0; a = 0; b = 0; cen = 0; c = 0;

    // Reset held, then a single full-scale ZERO op.
    repeat (3) step(0, 1, 2'd1, 17'h1FFFF, 17'h1FFFF, 1, 36'hFFF);
    check("reset p_o", 64'(p0), 0);
    check("reset valid_o", 64'(vo0), 0);
    step(1, 1, 2'd0, 17'h1FFFF, 17'h1FFFF, 0, '0);
    idle(1);
    check("early valid_o", 64'(vo0), 0);
    idle(1);
    check("first p_o", 64'(p0), 64'h3FFFC0001);
    check("first valid_o", 64'(vo0), 1);
    check("first carry_o", 64'(co0), 0);

    // Back-to-back ZERO then ADDPSH.
    step(1, 1, 2'd0, 17'h1FFFF, 17'h1FFFF, 0, '0);
    step(1, 1, 2'd3, 17'h1, 17'h1, 0, '0);
    idle(2);
    check("addpsh p_o", 64'(p0), 64'h1FFFF);
    idle(2);

    // Repeated accumulate into carry.
    step(1, 1, 2'd0, 17'h1FFFF, 17'h1FFFF, 0, '0);
    repeat (4) step(1, 1, 2'd2, 17'h1FFFF, 17'h1FFFF, 0, '0);
    idle(2);
    check("accum p_o", 64'(p0), 64'h3FFEC0005);
    check("accum carry_o", 64'(co0), 1);
    idle(2);

    // C register load then consume; then load in the consuming cycle.
    step(1, 0, 2'd0, '0, '0, 1, 36'h10);
    step(1, 1, 2'd1, 17'd2, 17'd3, 0, 36'h99);
    idle(2);
    check("addc p_o", 64'(p0), 64'h16);
    step(1, 1, 2'd1, 17'd2, 17'd3, 0, 36'h99);
    step(1, 0, 2'd0, '0, '0, 0, 36'h99);
    step(1, 0, 2'd0, '0, '0, 1, 36'h55);
    check("addc old Cq", 64'(p0), 64'h16);
    idle(3);

    // Bubble between two ops on the LAT=4 instance.
    step(1, 1, 2'd0, 17'd5, 17'd1, 0, '0);
    idle(1);
    step(1, 1, 2'd2, 17'd7, 17'd1, 0, '0);
    idle(1);
    check("lat4 first p_o", 64'(p1), 5);
    check("lat4 first valid_o", 64'(vo1), 1);
    idle(1);
    check("lat4 bubble valid_o", 64'(vo1), 0);
    check("lat4 bubble p_o", 64'(p1), 5);
    idle(1);
    check("lat4 second p_o", 64'(p1), 12);
    idle(2);

    // Reset while three ops are in flight.
    step(1, 1, 2'd0, 17'd9, 17'd9, 0, '0);
    step(1, 1, 2'd2, 17'd3, 17'd3, 0, '0);
    step(1, 1, 2'd2, 17'd4, 17'd4, 0, '0);
    step(0, 0, 2'd0, '0, '0, 0, '0);
    idle(4);
    check("post-reset p_o", 64'(p0), 0);
    step(1, 1, 2'd0, 17'd6, 17'd7, 0, '0);
    idle(2);
    check("post-reset op", 64'(p0), 42);
    idle(3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 59) != 0), 1'($urandom), 2'($urandom), W'($urandom), W'($urandom),
           1'($urandom), {4'($urandom), 32'($urandom)});
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_au_param.md
Name: pe_au_param

Overview:
- Parametrised successor of the PE arithmetic unit used in the FIOS Montgomery multiplier datapath.
- Performs an unsigned WIDTH x WIDTH multiply followed by a selectable accumulate: zero, C operand, previous P, or P shifted right by WIDTH (FIOS carry propagation).
- Operands enter with a valid strobe and a per-operation mode; both travel down a pipeline of configurable depth.
- Results leave with a matching valid and a carry-out flag.

Parameters:
- WIDTH, 17, operand width in bits (2..26).
- GUARD, 2, extra accumulator bits above 2*WIDTH.
- ABREG, 1, operand register stages before the multiplier (0..2).
- MREG, 1, multiplier output register stages (0..1).
- CREG, 1, C input register enable (0: C used combinationally, 1: registered via c_en_i).
- PW (local), 2*WIDTH+GUARD, accumulator/result width.
- LAT (local), ABREG+MREG+1, input-to-output latency in cycles.

Ports:
- clock_i  in  1  clock; all logic rising-edge.
- reset_n_i  in  1  synchronous active-low reset.
- valid_i  in  1  operation present on a_i/b_i/mode_i this cycle.
- mode_i  in  2  accumulate select: 00 ZERO, 01 ADDC, 10 ADDP, 11 ADDPSH.
- a_i  in  WIDTH  unsigned multiplicand.
- b_i  in  WIDTH  unsigned multiplier.
- c_en_i  in  1  C register load enable (ignored when CREG=0).
- c_i  in  PW  addend for ADDC.
- valid_o  out  1  p_o holds a new result.
- p_o  out  PW  accumulator register.
- carry_o  out  1  carry out of bit PW-1 from the last accumulate.

Behaviour:
- Reset (reset_n_i=0 at a clock edge): every pipeline stage register, including valid and mode, is cleared to 0. p_o=0, valid_o=0, carry_o=0, and the C register is cleared to 0. In-flight operations are discarded. The first op accepted after release emerges exactly LAT cycles later.
- Pipeline: a_i, b_i, mode_i and valid_i pass through ABREG stages and then the multiply. The product M=a*b (2*WIDTH bits, zero-extended to PW) passes through MREG stages. Mode and valid are delayed identically.
- Final stage (P register), on a cycle where the delayed valid is 1:
  - ZERO: P <= M.
  - ADDC: P <= M + Cq.
  - ADDPSH: P <= M + (P >> WIDTH).
  - ADDP: P <= M + P.
  - All sums are modulo 2^PW. carry_o is set to bit PW of the full sum, and valid_o is set to 1.
- Delayed valid = 0: P and carry_o hold, and valid_o=0.
- Latency: an op with valid_i=1 at edge t appears on p_o/valid_o after edge t+LAT-1, i.e. it is visible for the cycle following edge t+LAT-1. Equivalently, one op per cycle and full throughput.
- Feedback: ADDP and ADDPSH use the P register value at the moment the op reaches the final stage. Back-to-back ops are therefore hazard-free: op n+1 sees op n's result, with no stall.
- C path:
  - CREG=1: Cq loads c_i on edges where c_en_i=1, otherwise holds.
  - CREG=0: Cq = c_i combinationally in the final-stage cycle.
  - Cq is sampled in the cycle the ADDC op is in the final stage, not at issue. Loading C and consuming it in the same cycle uses the previous Cq.
- Bubbles: valid_i=0 cycles propagate as bubbles. P is never altered by a bubble.
- Widths: a_i/b_i are zero-extended. The product never exceeds 2*WIDTH bits. Overflow is detectable only via carry_o, and there is no saturation.
- Invalid parameters (ABREG>2, MREG>1, WIDTH outside 2..26) produce an elaboration error.

Test Plan:
- Default params, reset held 3 cycles then released; one op with valid_i=1, mode=00, a=0x1FFFF, b=0x1FFFF.
  -> p_o=0 and valid_o=0 during reset; p_o=0x3FFFC0001, valid_o=1, carry_o=0 exactly 3 cycles after issue.
- Back-to-back ops: op 1 as above, then next cycle mode=11, a=1, b=1.
  -> second result is 0x1 + (0x3FFFC0001>>17) = 0x1FFFF, on the cycle after the first result.
- Repeated accumulate: mode=00 with 0x1FFFF*0x1FFFF, then four consecutive mode=10 ops with the same operands.
  -> p_o sequence 0x3FFFC0001, 0x7FFF80002, 0xBFFF40003, 0xFFFF00004 (carry 0), then 0x3FFEC0005 with carry_o=1.
- C register (CREG=1): c_en_i=1 with c_i=0x10 one cycle, then c_i=0x99 with c_en_i=0; issue mode=01, a=2, b=3.
  -> p_o=0x16. Repeat with c_en_i=1 in the same cycle as the op reaches the final stage -> old Cq is used.
- ABREG=2, MREG=1 (LAT=4): ops at cycles 0 and 2 with a bubble between, modes 00 and 10, a*b=5 and 7.
  -> valid_o high at cycles 4 and 6 only; p_o=5 then 12; p_o holds 5 during the bubble.
- Reset mid-operation: issue 3 ops, assert reset_n_i low for 1 cycle while they are in flight.
  -> no valid_o from the dropped ops; p_o=0 afterwards; next op's result appears exactly LAT cycles after issue.
